// File: rtl/id_issue_queue_ctrl_pkg.sv
// Shared types for the decode-to-issue instruction queue.
// Lane count, default payload width and the queued entry layout.
package id_queue_pkg;

  localparam int unsigned NR_LANES     = 2;
  localparam int unsigned QUEUE_DATA_W = 64;

  typedef struct packed {
    logic [QUEUE_DATA_W-1:0] data;
    logic                    ctrl_flow;
  } id_queue_entry_t;

  function automatic logic [1:0] lane_cnt(
    input logic l0,
    input logic l1
  );
    return {1'b0, l0} + {1'b0, l1};
  endfunction

endpackage

// File: rtl/id_issue_queue_ctrl_if.sv
// Dual-lane enqueue/dequeue handshake bundle of the issue queue.
// master = decode/issue side, slave = the queue controller.
interface id_issue_queue_ctrl_if #(
  parameter int unsigned DATA_W = id_queue_pkg::QUEUE_DATA_W
);

  localparam int unsigned L = id_queue_pkg::NR_LANES;

  logic [L-1:0]             enq_valid_i;
  logic [L-1:0][DATA_W-1:0] enq_data_i;
  logic [L-1:0]             enq_ctrl_flow_i;
  logic [L-1:0]             enq_ready_o;

  logic [L-1:0]             deq_valid_o;
  logic [L-1:0][DATA_W-1:0] deq_data_o;
  logic [L-1:0]             deq_ctrl_flow_o;
  logic [L-1:0]             deq_ack_i;

  modport master (
    output enq_valid_i,
    output enq_data_i,
    output enq_ctrl_flow_i,
    input  enq_ready_o,
    input  deq_valid_o,
    input  deq_data_o,
    input  deq_ctrl_flow_o,
    output deq_ack_i
  );

  modport slave (
    input  enq_valid_i,
    input  enq_data_i,
    input  enq_ctrl_flow_i,
    output enq_ready_o,
    output deq_valid_o,
    output deq_data_o,
    output deq_ctrl_flow_o,
    input  deq_ack_i
  );

endinterface

// File: rtl/id_issue_queue_ctrl.sv
// In-order dual-lane circular queue between decode and issue.
// Control-flow at the head serializes issue to lane 0 only.
module id_issue_queue_ctrl
  import id_queue_pkg::*;
#(
  parameter int unsigned NR_ENTRIES = 4,
  parameter int unsigned DATA_W     = QUEUE_DATA_W,
  localparam int unsigned PTR_W     = $clog2(NR_ENTRIES),
  localparam int unsigned CNT_W     = $clog2(NR_ENTRIES + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 stall_i,
  id_issue_queue_ctrl_if.slave q,
  output logic [CNT_W-1:0]     count_o,
  output logic                 empty_o,
  output logic                 full_o
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              ctrl_flow;
  } entry_t;

  entry_t           mem_q [NR_ENTRIES];
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_nxt;
  logic [PTR_W-1:0] wr_nxt;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] free;
  logic             enq_ok;
  logic             acc0;
  logic             acc1;
  logic             pop0;
  logic             pop1;
  logic [1:0]       n_acc;
  logic [1:0]       n_pop;
  entry_t           head;
  entry_t           head_nxt;

  assign rd_nxt = rd_ptr_q + PTR_W'(1);
  assign wr_nxt = wr_ptr_q + PTR_W'(1);

  // Ready depends only on the registered count, never on deq_ack_i.
  always_comb begin
    free   = CNT_W'(NR_ENTRIES) - count_q;
    enq_ok = !stall_i && !flush_i;
    q.enq_ready_o[0] = enq_ok && (free > CNT_W'(0));
    q.enq_ready_o[1] = enq_ok && (free > CNT_W'(1));
  end

  always_comb begin
    head     = mem_q[rd_ptr_q];
    head_nxt = mem_q[rd_nxt];
    q.deq_valid_o[0]     = (count_q != CNT_W'(0));
    q.deq_valid_o[1]     = (count_q >= CNT_W'(2))
                        && !head.ctrl_flow;
    q.deq_data_o[0]      = head.data;
    q.deq_data_o[1]      = head_nxt.data;
    q.deq_ctrl_flow_o[0] = head.ctrl_flow;
    q.deq_ctrl_flow_o[1] = head_nxt.ctrl_flow;
  end

  always_comb begin
    acc0  = q.enq_valid_i[0] && q.enq_ready_o[0];
    acc1  = q.enq_valid_i[1] && q.enq_ready_o[1] && acc0;
    pop0  = q.deq_ack_i[0] && q.deq_valid_o[0];
    pop1  = q.deq_ack_i[1] && q.deq_valid_o[1] && pop0;
    n_acc = lane_cnt(acc0, acc1);
    n_pop = lane_cnt(pop0, pop1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_q + PTR_W'(n_pop);
      wr_ptr_q <= wr_ptr_q + PTR_W'(n_acc);
      count_q  <= count_q + CNT_W'(n_acc)
                          - CNT_W'(n_pop);
    end
  end

  // Payload storage is deliberately left unreset.
  always_ff @(posedge clk_i) begin
    if (acc0) begin
      mem_q[wr_ptr_q] <= '{data:      q.enq_data_i[0],
                           ctrl_flow: q.enq_ctrl_flow_i[0]};
    end
    if (acc1) begin
      mem_q[wr_nxt] <= '{data:      q.enq_data_i[1],
                         ctrl_flow: q.enq_ctrl_flow_i[1]};
    end
  end

  assign count_o = count_q;
  assign empty_o = (count_q == CNT_W'(0));
  assign full_o  = (count_q == CNT_W'(NR_ENTRIES));

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (count_q <= CNT_W'(NR_ENTRIES));
      assert (CNT_W'(n_acc) <= free);
      assert (CNT_W'(n_pop) <= count_q);
    end
  end

endmodule

// File: tb/tb_id_issue_queue_ctrl.sv
// Scoreboard bench for id_issue_queue_ctrl: directed + random.
// Reference is a plain SV queue of entries updated per cycle.
module tb_id_issue_queue_ctrl;
  import id_queue_pkg::*;

  localparam int N  = 4;
  localparam int DW = QUEUE_DATA_W;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       stall;
  logic [2:0] count;
  logic       empty;
  logic       full;

  id_issue_queue_ctrl_if #(.DATA_W(DW)) q_if ();

  id_issue_queue_ctrl #(
    .NR_ENTRIES(N),
    .DATA_W    (DW)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .flush_i(flush),
    .stall_i(stall),
    .q      (q_if.slave),
    .count_o(count),
    .empty_o(empty),
    .full_o (full)
  );

  always #5 clk = ~clk;

  id_queue_entry_t ref_q[$];
  int n_vec   = 0;
  int n_err   = 0;
  int n_proto = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference model: queue semantics straight from the rules.
  always @(posedge clk) begin
    int sz;
    logic r0, r1, a0, a1, p0, p1, v1;
    id_queue_entry_t e;
    sz = ref_q.size();
    if (rst || flush) begin
      ref_q.delete();
    end else begin
      r0 = !stall && (N - sz > 0);
      r1 = !stall && (N - sz > 1);
      a0 = q_if.enq_valid_i[0] && r0;
      a1 = q_if.enq_valid_i[1] && r1 && a0;
      v1 = (sz >= 2) && !ref_q[0].ctrl_flow;
      p0 = q_if.deq_ack_i[0] && (sz >= 1);
      p1 = q_if.deq_ack_i[1] && v1 && p0;
      if ((q_if.deq_ack_i[1] && !q_if.deq_ack_i[0])
          || (q_if.deq_ack_i[0] && sz < 1)
          || (q_if.deq_ack_i[1] && !v1))
        n_proto++;
      if (p0) void'(ref_q.pop_front());
      if (p1) void'(ref_q.pop_front());
      if (a0) begin
        e.data      = q_if.enq_data_i[0];
        e.ctrl_flow = q_if.enq_ctrl_flow_i[0];
        ref_q.push_back(e);
      end
      if (a1) begin
        e.data      = q_if.enq_data_i[1];
        e.ctrl_flow = q_if.enq_ctrl_flow_i[1];
        ref_q.push_back(e);
      end
    end
  end

  task automatic check_outputs();
    int sz;
    logic [1:0] erdy;
    logic [1:0] ev;
    sz = ref_q.size();
    erdy[0] = !stall && !flush && (N - sz > 0);
    erdy[1] = !stall && !flush && (N - sz > 1);
    ev[0]   = (sz >= 1);
    ev[1]   = (sz >= 2) && !ref_q[0].ctrl_flow;
    chk("count", 64'(count), 64'(sz));
    chk("empty", 64'(empty), 64'(sz == 0));
    chk("full",  64'(full),  64'(sz == N));
    chk("enq_ready", 64'(q_if.enq_ready_o), 64'(erdy));
    chk("deq_valid", 64'(q_if.deq_valid_o), 64'(ev));
    if (ev[0]) begin
      chk("deq_data0", q_if.deq_data_o[0], ref_q[0].data);
      chk("deq_cf0", 64'(q_if.deq_ctrl_flow_o[0]),
          64'(ref_q[0].ctrl_flow));
    end
    if (ev[1]) begin
      chk("deq_data1", q_if.deq_data_o[1], ref_q[1].data);
      chk("deq_cf1", 64'(q_if.deq_ctrl_flow_o[1]),
          64'(ref_q[1].ctrl_flow));
    end
  endtask

  // Monitor: compares DUT outputs against the scoreboard mid-cycle.
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      check_outputs();
    end
  end

  task automatic drive(input logic st, input logic fl,
                       input logic [1:0] ev,
                       input logic [1:0] cf,
                       input logic [1:0] ack);
    stall = st;
    flush = fl;
    q_if.enq_valid_i     = ev;
    q_if.enq_ctrl_flow_i = cf;
    q_if.deq_ack_i       = ack;
    q_if.enq_data_i[0]   = {$urandom, $urandom};
    q_if.enq_data_i[1]   = {$urandom, $urandom};
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst   = 1'b1;
    flush = 1'b0;
    stall = 1'b0;
    q_if.enq_valid_i     = '0;
    q_if.enq_data_i      = '0;
    q_if.enq_ctrl_flow_i = '0;
    q_if.deq_ack_i       = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    drive(0, 0, 2'b00, 2'b00, 2'b00);
    drive(0, 0, 2'b00, 2'b00, 2'b00);
    // fill to full, then full + ack + enq in one cycle
    drive(0, 0, 2'b11, 2'b00, 2'b00);
    drive(0, 0, 2'b11, 2'b00, 2'b00);
    drive(0, 0, 2'b00, 2'b00, 2'b00);
    drive(0, 0, 2'b11, 2'b00, 2'b11);
    drive(0, 0, 2'b11, 2'b00, 2'b00);
    drive(0, 0, 2'b00, 2'b00, 2'b11);
    drive(0, 0, 2'b00, 2'b00, 2'b11);
    // stall blocks enqueue
    drive(1, 0, 2'b11, 2'b00, 2'b00);
    // control-flow head
    drive(0, 0, 2'b11, 2'b01, 2'b00);
    drive(0, 0, 2'b01, 2'b00, 2'b00);
    drive(0, 0, 2'b00, 2'b00, 2'b00);
    drive(0, 0, 2'b00, 2'b00, 2'b01);
    drive(0, 0, 2'b00, 2'b00, 2'b00);
    drive(0, 0, 2'b00, 2'b00, 2'b11);
    // pointer wrap streaming
    drive(0, 0, 2'b01, 2'b00, 2'b00);
    for (int i = 0; i < 10; i++)
      drive(0, 0, 2'b01, 2'b00, 2'b01);
    drive(0, 0, 2'b00, 2'b00, 2'b01);
    // flush with traffic in the same cycle
    drive(0, 0, 2'b11, 2'b00, 2'b00);
    drive(0, 0, 2'b01, 2'b00, 2'b00);
    drive(0, 1, 2'b11, 2'b00, 2'b01);
    drive(0, 0, 2'b00, 2'b00, 2'b00);

    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(99) == 0);
      drive($urandom_range(9) == 0,
            $urandom_range(29) == 0,
            2'($urandom),
            {$urandom_range(3) == 0,
             $urandom_range(3) == 0},
            2'($urandom));
      rst = 1'b0;
    end
    drive(0, 0, 2'b00, 2'b00, 2'b00);

    $display("note: %0d out-of-protocol acks injected",
             n_proto);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
